// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// the helper that sizes the bit counter.
package adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of bits needed to count 0..w-1, never less than one.
   function automatic int cnt_width(input int w);
      int r;
      r = 0;
      while ((1 << r) < w) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the only arithmetic element of the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel and summed
// LSB-first through one full_adder, with the carry registered between bits.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] next_sum_sh;
   logic             last_bit;

   full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New result bits enter at the MSB so the LSB-first stream lands in place.
   generate
      if (WIDTH == 1) begin : g_w1
         assign next_sum_sh = fa_sum;
      end else begin : g_wn
         assign next_sum_sh = {fa_sum, sum_sh_q[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_sh_d = next_sum_sh;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d   = next_sum_sh;
               cout_d  = fa_cout;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, plus a WIDTH=1 instance.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       busy, done, cout;
   logic [7:0] sum;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] last_sum = '0;
   logic       last_cout = 1'b0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   always #5 clk = ~clk;

   task checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts one operation (DUT must be idle or done), waits for done and checks
   // latency, busy length, result, and that the old result held during the run.
   task applyStimulus(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic icin, input bit hold, input int inject_at);
      logic [8:0] exp;
      int         edges;
      int         busy_cnt;
      bit         stable;
      exp = {1'b0, ia} + {1'b0, ib} + {8'd0, icin};
      a = ia; b = ib; cin = icin; start = 1'b1;
      @(posedge clk); #1;
      edges = 0; busy_cnt = 0; stable = 1'b1;
      if (!hold) start = 1'b0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         if (sum !== last_sum || cout !== last_cout) stable = 1'b0;
         if (!hold) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
         if (edges == inject_at) begin
            start = 1'b1; a = 8'h11;
         end else if (!hold) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
      end
      checkOutput({tag, "_latency"}, 64'(edges + 1), 64'd9);
      checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
      checkOutput({tag, "_sum_held"}, 64'(stable), 64'd1);
      checkOutput({tag, "_sum"}, 64'(sum), 64'(exp[7:0]));
      checkOutput({tag, "_cout"}, 64'(cout), 64'(exp[8]));
      last_sum = exp[7:0];
      last_cout = exp[8];
   endtask

   initial begin
      int seen;
      int edges;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_sum", 64'(sum), 64'd0);
      checkOutput("rst_cout", 64'(cout), 64'd0);
      checkOutput("rst_w1_done", 64'(done1), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus("t1", 8'h3C, 8'h42, 1'b0, 1'b0, -1);
      @(posedge clk); #1;
      checkOutput("t1_done_pulse", 64'(done), 64'd0);
      checkOutput("t1_back_idle", 64'(busy), 64'd0);
      checkOutput("t1_sum_after", 64'(sum), 64'h7E);

      applyStimulus("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, -1);
      applyStimulus("t2b", 8'hA5, 8'h5A, 1'b1, 1'b0, -1);

      applyStimulus("t3", 8'h3C, 8'h42, 1'b0, 1'b0, 3);

      applyStimulus("t4a", 8'h01, 8'h01, 1'b0, 1'b1, -1);
      applyStimulus("t4b", 8'h02, 8'h02, 1'b0, 1'b1, -1);
      applyStimulus("t4c", 8'h80, 8'h80, 1'b0, 1'b1, -1);
      start = 1'b0;
      @(posedge clk); #1;
      checkOutput("t4_done_pulse", 64'(done), 64'd0);
      checkOutput("t4_idle", 64'(busy), 64'd0);

      // Abort mid-run: outputs clear immediately and no done ever appears.
      a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_busy", 64'(busy), 64'd0);
      checkOutput("t5_rst_sum", 64'(sum), 64'd0);
      checkOutput("t5_rst_cout", 64'(cout), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      checkOutput("t5_no_done", 64'(seen), 64'd0);
      last_sum = '0;
      last_cout = 1'b0;
      applyStimulus("t5", 8'h0F, 8'hF0, 1'b1, 1'b0, -1);

      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      edges = 0;
      while (!done1 && edges < 10) begin
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("t6_latency", 64'(edges + 1), 64'd2);
      checkOutput("t6_sum", 64'(sum1), 64'd1);
      checkOutput("t6_cout", 64'(cout1), 64'd1);

      for (int i = 0; i < 1000; i++) begin
         applyStimulus("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
